axis_hsmooth3: RTL and testbench



---
 rtl/axis_hsmooth3.sv | 142 ++++++++++++++
 tb/tb_axis_hsmooth3.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/axis_hsmooth3.sv
// Horizontal [1 2 1]/4 smoothing stage for an AXI-Stream raster, one pixel per beat.
// Replicate padding at line edges; the frame-end marker is carried through to the output.
module axis_hsmooth3 #(
    parameter int IMG_WIDTH   = 640,
    parameter int INPUT_BITS  = 8,
    parameter int OUTPUT_BITS = 8
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [INPUT_BITS-1:0]  axis_m_data_i,
    input  logic                   axis_m_valid_i,
    output logic                   axis_m_ready_o,
    input  logic                   axis_m_last_i,
    output logic [OUTPUT_BITS-1:0] axis_s_data_o,
    output logic                   axis_s_valid_o,
    input  logic                   axis_s_ready_i,
    output logic                   axis_s_last_o
);

    localparam int CW = $clog2(IMG_WIDTH + 1);
    localparam int SW = INPUT_BITS + 2;

    generate
        if (IMG_WIDTH < 2) begin : g_bad_width
            $error("axis_hsmooth3: IMG_WIDTH must be at least 2");
        end
        if (OUTPUT_BITS < INPUT_BITS) begin : g_bad_out_bits
            $error("axis_hsmooth3: OUTPUT_BITS must be at least INPUT_BITS");
        end
    endgenerate

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [INPUT_BITS-1:0] prev_q, prev_d;
    logic [INPUT_BITS-1:0] cur_q, cur_d;
    logic                  pend_last_q, pend_last_d;

    logic                  slot_free;
    logic                  accept;
    logic                  out_load;
    logic [INPUT_BITS-1:0] out_pix;
    logic                  out_last;
    logic [SW-1:0]         sum_run;
    logic [SW-1:0]         sum_flush;

    assign slot_free      = !axis_s_valid_o || axis_s_ready_i;
    assign axis_m_ready_o = rstn_i && ((state_q == FILL) || (state_q == RUN && slot_free));
    assign accept         = axis_m_valid_i && axis_m_ready_o;

    // Worst case is 4*max+2, which fits SW bits; +2 rounds half up before the >>2.
    assign sum_run   = SW'(prev_q) + (SW'(cur_q) << 1) + SW'(axis_m_data_i) + SW'(2);
    assign sum_flush = SW'(prev_q) + (SW'(cur_q) << 1) + SW'(cur_q) + SW'(2);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        col_d       = col_q;
        prev_d      = prev_q;
        cur_d       = cur_q;
        pend_last_d = pend_last_q;
        out_load    = 1'b0;
        out_pix     = '0;
        out_last    = 1'b0;

        case (state_q)
            FILL: begin
                if (accept) begin
                    prev_d      = axis_m_data_i;
                    cur_d       = axis_m_data_i;
                    col_d       = CW'(1);
                    pend_last_d = axis_m_last_i;
                    state_d     = axis_m_last_i ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    out_load = 1'b1;
                    out_pix  = sum_run[SW-1:2];
                    prev_d   = cur_q;
                    cur_d    = axis_m_data_i;
                    col_d    = col_q + CW'(1);
                    if (col_q == CW'(IMG_WIDTH - 1) || axis_m_last_i) begin
                        pend_last_d = axis_m_last_i;
                        state_d     = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // Line-end pixel: the missing right neighbour is replaced by the pixel itself.
                if (slot_free) begin
                    out_load    = 1'b1;
                    out_pix     = sum_flush[SW-1:2];
                    out_last    = pend_last_q;
                    col_d       = '0;
                    pend_last_d = 1'b0;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= FILL;
            col_q       <= '0;
            prev_q      <= '0;
            cur_q       <= '0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            pend_last_q <= pend_last_d;
        end
    end

    // Output register only changes when empty or being accepted.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            axis_s_valid_o <= 1'b0;
            axis_s_last_o  <= 1'b0;
            axis_s_data_o  <= '0;
        end else if (out_load) begin
            axis_s_valid_o <= 1'b1;
            axis_s_last_o  <= out_last;
            axis_s_data_o  <= OUTPUT_BITS'(out_pix);
        end else if (axis_s_ready_i) begin
            axis_s_valid_o <= 1'b0;
            axis_s_last_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_hsmooth3.sv
// Scoreboard bench for axis_hsmooth3 at IMG_WIDTH=4 with hand-computed expected pixels.
module tb_axis_hsmooth3;

    localparam int W  = 4;
    localparam int IB = 8;
    localparam int OB = 8;

    typedef struct packed {
        logic [OB-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic [IB-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [OB-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          s_last;

    int    checks   = 0;
    int    failures = 0;
    beat_t sb[$];

    logic          prev_stall;
    logic [OB-1:0] held_d;
    logic          held_l;

    axis_hsmooth3 #(.IMG_WIDTH(W), .INPUT_BITS(IB), .OUTPUT_BITS(OB)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .axis_m_data_i (m_data),
        .axis_m_valid_i(m_valid),
        .axis_m_ready_o(m_ready),
        .axis_m_last_i (m_last),
        .axis_s_data_o (s_data),
        .axis_s_valid_o(s_valid),
        .axis_s_ready_i(s_ready),
        .axis_s_last_o (s_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_px(input logic [OB-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        sb.push_back(b);
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send(input logic [IB-1:0] d, input logic l);
        int n = 0;
        m_valid = 1'b1;
        m_data  = d;
        m_last  = l;
        @(negedge clk);
        while (!m_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) check("send_timeout", 32'(m_ready), 1);
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        m_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: a beat presented with valid&&ready at the falling edge transfers on the next rising edge.
    always @(negedge clk) begin
        if (rstn && prev_stall) begin
            check("hold_valid", 32'(s_valid), 1);
            check("hold_data", 32'(s_data), 32'(held_d));
            check("hold_last", 32'(s_last), 32'(held_l));
        end
        if (rstn && s_valid && s_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", sb.size(), 1);
            end else begin
                beat_t b;
                b = sb.pop_front();
                check("out_data", 32'(s_data), 32'(b.data));
                check("out_last", 32'(s_last), 32'(b.last));
            end
        end
        prev_stall <= rstn && s_valid && !s_ready;
        held_d     <= s_data;
        held_l     <= s_last;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; m_valid = 1'b0; m_data = '0; m_last = 1'b0; s_ready = 1'b1;
        #12;
        check("rst_valid", 32'(s_valid), 0);
        check("rst_last", 32'(s_last), 0);
        check("rst_data", 32'(s_data), 0);
        check("rst_m_ready", 32'(m_ready), 0);
        @(posedge clk); #1; rstn = 1'b1;
        @(posedge clk); #1;

        // Basic line with one ready-low cycle while flushing.
        expect_px(13, 0); expect_px(20, 0); expect_px(30, 0); expect_px(38, 1);
        send(10, 0); send(20, 0); send(30, 0); send(40, 1);
        s_ready = 1'b0;
        @(posedge clk); #1;
        s_ready = 1'b1;
        drain();

        // Two lines, no blending across the boundary.
        for (int i = 0; i < 8; i++) expect_px((i < 4) ? 8'd0 : 8'd255, i == 7);
        for (int i = 0; i < 8; i++) send((i < 4) ? 8'd0 : 8'd255, i == 7);
        drain();

        // Saturated input must not wrap.
        for (int i = 0; i < 4; i++) expect_px(255, i == 3);
        for (int i = 0; i < 4; i++) send(255, i == 3);
        drain();

        // Single-pixel frame.
        expect_px(77, 1);
        send(77, 1);
        drain();

        // Early last, then a fresh line.
        expect_px(5, 0); expect_px(8, 0); expect_px(11, 1);
        for (int i = 0; i < 4; i++) expect_px(100, i == 3);
        send(4, 0); send(8, 0); send(12, 1);
        for (int i = 0; i < 4; i++) send(100, i == 3);
        drain();

        // Mid-line downstream stall of 5 cycles.
        expect_px(13, 0); expect_px(20, 0); expect_px(30, 0); expect_px(38, 1);
        send(10, 0); send(20, 0);
        s_ready = 1'b0;
        fork
            send(30, 0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("stall_m_ready", 32'(m_ready), 0);
                end
                @(posedge clk); #1;
                s_ready = 1'b1;
            end
        join
        send(40, 1);
        drain();

        // Reset mid-line discards the held beat and all line state.
        s_ready = 1'b0;
        send(10, 0); send(20, 0);
        check("pre_rst_valid", 32'(s_valid), 1);
        rstn = 1'b0;
        #1;
        check("midrst_valid", 32'(s_valid), 0);
        check("midrst_m_ready", 32'(m_ready), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        s_ready = 1'b1;
        @(posedge clk); #1;
        expect_px(13, 0); expect_px(20, 0); expect_px(30, 0); expect_px(38, 1);
        send(10, 0); send(20, 0); send(30, 0); send(40, 1);
        drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
